// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: the fetch queue entry layout and its default depth.
package mips_core_pkg;

    localparam int FETCH_QUEUE_DEPTH = 4;
    localparam int FQ_ADDR_WIDTH     = 32;
    localparam int FQ_DATA_WIDTH     = 32;

    typedef struct packed {
        logic [FQ_ADDR_WIDTH-1:0] pc;
        logic [FQ_DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: DEPTH entries, one synchronous write port, one asynchronous read port.
// Entries carry no reset; the control logic gates every read with its valid flag.
module fetch_queue_ram
    import mips_core_pkg::*;
#(
    parameter int  DEPTH   = FETCH_QUEUE_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  entry_t                   i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output entry_t                   o_rd_data
);

    entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between i_cache and decode, with flush on branch/jump redirect.
// Defining FETCH_QUEUE_BYPASS_EN lets an empty queue forward its input to decode in the same cycle.
module fetch_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = FETCH_QUEUE_DEPTH,
    parameter int ADDR_WIDTH = FQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = FQ_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_in_valid,
    input  logic [ADDR_WIDTH-1:0]      i_in_pc,
    input  logic [DATA_WIDTH-1:0]      i_in_inst,
    output logic                       o_in_ready,
    input  logic                       i_flush,
    output logic                       o_out_valid,
    output logic [ADDR_WIDTH-1:0]      o_out_pc,
    output logic [DATA_WIDTH-1:0]      o_out_inst,
    input  logic                       i_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic   w_full;
    logic   w_empty;
    logic   w_head_valid;
    logic   w_bypass;
    logic   w_push;
    logic   w_pop;
    logic   w_wr_en;
    logic   w_rd_en;
    entry_t w_in_entry;
    entry_t w_rd_entry;
    entry_t w_out_entry;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign o_in_ready = !w_full;
    assign o_count    = r_count;

    assign w_in_entry.pc   = i_in_pc;
    assign w_in_entry.inst = i_in_inst;

    // A flush cycle never presents an entry, so decode cannot consume wrong-path work.
    assign w_head_valid = !w_empty && !i_flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && i_in_valid && !i_flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign o_out_valid = w_head_valid || w_bypass;
    assign w_out_entry = w_bypass ? w_in_entry : w_rd_entry;
    assign o_out_pc    = o_out_valid ? w_out_entry.pc   : '0;
    assign o_out_inst  = o_out_valid ? w_out_entry.inst : '0;

    assign w_push = i_in_valid && !w_full && !i_flush;
    assign w_pop  = o_out_valid && i_out_ready && !i_flush;

    // A bypassed entry that decode takes immediately is never written into storage.
    assign w_wr_en = w_push && !(w_bypass && i_out_ready);
    assign w_rd_en = w_pop && !w_bypass;

    fetch_queue_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_in_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between the instruction cache and decode. Each cycle the i_cache returns a valid instruction, the queue captures the `{pc, instruction}` pair and presents entries in order to decode through a valid/ready handshake. `in_ready` deasserts when the queue is full; the hazard controller folds `!in_ready` into the fetch stall. A `flush` from the branch/jump redirect path (the same event that asserts the load-pc write enable) discards every queued entry so that wrong-path instructions never reach decode.

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥ 2.
- `ADDR_WIDTH`, default 32: width of the pc field.
- `DATA_WIDTH`, default 32: width of the instruction field.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: the i_cache presents a valid instruction this cycle.
- `in_pc`, in, ADDR_WIDTH: pc of the incoming instruction.
- `in_inst`, in, DATA_WIDTH: incoming instruction word.
- `in_ready`, out, 1: queue can accept an entry. Equal to `!full`. It is registered-state-derived and has no combinational path from `out_ready`.
- `flush`, in, 1: discard all entries and the current input.
- `out_valid`, out, 1: the head entry is valid.
- `out_pc`, out, ADDR_WIDTH: pc of the head entry.
- `out_inst`, out, DATA_WIDTH: instruction of the head entry.
- `out_ready`, in, 1: decode consumes the head this cycle.
- `count`, out, $clog2(DEPTH+1): current occupancy, for debug and performance counters.

## Operation
- Storage is a circular buffer of DEPTH entries. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. An occupancy counter tracks fill level.
- Push occurs when `in_valid && in_ready && !flush`.
- Pop occurs when `out_valid && out_ready && !flush`.
- Simultaneous push and pop when the queue is non-empty: both pointers advance and `count` is unchanged.
- Full (`count == DEPTH`): `in_ready` = 0, even if a pop happens the same cycle. While full, `in_valid` is ignored.
- Empty (`count == 0`): `out_valid` = 0, and `out_pc`/`out_inst` are driven to `'0`. A pop cannot occur.
- Flush has priority over everything else. On the next edge both pointers and `count` go to 0, and any push or pop in the flush cycle is suppressed. During the flush cycle `out_valid` is forced to 0 combinationally, so decode never consumes an entry in a flush cycle.
- Ordering is strictly FIFO; entries are never reordered or dropped except by flush.

## Timing
- Reset (asynchronous): pointers = 0, `count` = 0. This gives `out_valid` = 0, `out_pc` = 0, `out_inst` = 0, and `in_ready` = 1.
- Latency without bypass: an entry pushed at edge N is visible on the outputs in cycle N+1.
- Throughput: one push and one pop per cycle in steady state.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge. Contents are lost.
- Storage entries themselves need no reset. Outputs are gated by `out_valid`.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when the queue is empty and `in_valid && !flush`:
  - `out_valid` = 1 in the same cycle, with `out_pc`/`out_inst` taken directly from the inputs.
  - If `out_ready` is also 1, the entry is consumed and not written, so `count` stays 0.
  - Otherwise the entry is written normally.
  - This creates a combinational path from input to output with zero-cycle latency.
- `FETCH_QUEUE_BYPASS_EN` undefined: no bypass. Minimum latency is 1 cycle, and all outputs are derived from registered state.

## Structure
- The shared package `mips_core_pkg`/`mips_core.svh` holds:
  - a `fetch_entry_t` struct `{pc, inst}` sized by ADDR_WIDTH/DATA_WIDTH;
  - the default `FETCH_QUEUE_DEPTH` constant.
- One sub-module, `fetch_queue_ram`: a DEPTH × `fetch_entry_t` array with one synchronous write port and one asynchronous read port. Pointer and count control logic lives in `fetch_queue`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle with `count`=3 → `count`=0, `out_valid`=0, `out_pc`=0, `in_ready`=1 immediately, before the next edge.
- **Fill and drain:** push pcs 0x00, 0x04, 0x08, 0x0C with `out_ready`=0 → `count`=4, `in_ready`=0. A fifth push of 0x10 is ignored. Then hold `out_ready`=1 → outputs 0x00, 0x04, 0x08, 0x0C on consecutive cycles, then `out_valid`=0.
- **Wrap-around:** perform 10 pushes and 10 pops interleaved at `count`≈2 → pcs emerge in order 0x00 through 0x24 with no loss or duplication across the pointer wrap.
- **Simultaneous push and pop while full:** `count`=4, `in_valid`=1, `out_ready`=1 → the pop occurs, the push is rejected, and `count`=3 next cycle.
- **Flush:** `count`=3, with `flush`=1, `in_valid`=1 and `out_ready`=1 in the same cycle → `out_valid`=0 during that cycle, and `count`=0 next cycle. A subsequent push of 0x40 is the next output.
- **Bypass:** with `FETCH_QUEUE_BYPASS_EN` defined, an empty queue, `in_valid`=1, `in_pc`=0x100 and `out_ready`=1 → `out_valid`=1 with `out_pc`=0x100 in the same cycle, and `count` stays 0. With the macro undefined, the same stimulus gives `out_pc`=0x100 one cycle later.
